alu_ctl_issue: RTL and testbench
================================

// Module: alu_ctl_issue
// PURPOSE
//  Decode-side producer of the 4-bit ALU control code and shift/immediate operands that drive the ALU.
//  Accepts a fetched MIPS instruction word over a valid/ready handshake and decodes opcode/funct to ALU control.
//  Presents a registered ID/EX control bundle downstream; one-entry skid buffer gives full throughput under backpressure.
//  Sits between the fetch/ID stage and the EX-stage ALU; flush kills in-flight entries on branch/jump redirect.
// PARAMETERS
//  DATA_W   32  instruction and immediate width (fixed 32 for MIPS-I; other values unsupported)
//  CTL_W    4   ALU control code width
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  flush        in   1      synchronous kill of all held entries
//  in_valid     in   1      instruction word present
//  in_ready     out  1      block can accept an instruction this cycle
//  in_instr     in   32     instruction word
//  out_valid    out  1      control bundle valid
//  out_ready    in   1      EX stage accepts bundle this cycle
//  out_alu_ctl  out  4      ALU control code
//  out_shamt    out  5      instr[10:6] for sll/srl, else 0
//  out_imm      out  32     extended immediate
//  out_use_imm  out  1      ALU B operand = out_imm (else rt)
//  out_illegal  out  1      opcode/funct not in decode table
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, all data outputs 0.
//  Latency: accepted instr (in_valid&in_ready) appears on out_* next cycle. Throughput 1/cycle.
//  Handshake: out_* stable while out_valid&~out_ready; in_ready is a registered ~skid_valid (no comb in->out path).
//  Skid: if out reg holds unaccepted data and an input is accepted, input goes to skid; skid drains to out reg
//   on the next out_ready cycle; in_ready=0 while skid full. Simultaneous drain+accept with empty skid: out reg reloads.
//  flush=1: out_valid<=0, skid cleared, same-cycle input discarded; flush overrides in_valid and out_ready.
//  R-type (op 000000) funct -> ctl: 100000 add 0010; 100001 addu 0011; 100010 sub 0110; 100011 subu 0110;
//   100100 and 0000; 100101 or 0001; 100110 xor 1011; 101010 slt 0111; 000000 sll 1001; 000010 srl 1010;
//   001000 jr 0010. use_imm=0, imm=0.
//  I/J-type op -> ctl: 001000 addi 0010; 001001 addiu 0011; 001010 slti 0111; 001100 andi 0000; 001101 ori 0001;
//   001110 xori 1011; 001111 lui 1000; 100011 lw 0010; 101011 sw 0010; 000100 beq 0110; 000101 bne 0110;
//   000010 j 0010; 000011 jal 1110. use_imm=1 for addi..lui,lw,sw; 0 for beq,bne,j,jal.
//  Immediate: zero-extend instr[15:0] for andi/ori/xori/lui; sign-extend for all other use_imm ops.
//  Anything else: illegal=1, ctl=0000, use_imm=0, imm=0, shamt=0; bundle still issued (EX raises exception).
//  sll with instr==0 (nop) is legal: ctl 1001, shamt 0.
// STRUCTURE
//  Package mips_alu_pkg: ALU_* ctl localparams (ADD 0010, ADDU 0011, SUB 0110, AND 0000, OR 0001, SLT 0111,
//   SLL 1001, SRL 1010, LUI 1000, XOR 1011, PASSA 1110), OP_*/FN_* constants, ctl bundle struct typedef.
//  Sub-module alu_ctl_lut: purely combinational instr -> bundle decode; top holds out reg, skid reg, handshake.
// TESTING
//  Reset mid-stream: out_valid=1 with skid full, pulse rst_n low -> out_valid=0, in_ready=1 immediately.
//  Decode sweep, out_ready=1: addi $1,$0,-1 (0x2001FFFF) -> ctl 0010, use_imm 1, imm 0xFFFFFFFF, next cycle.
//  ori 0x3401FFFF -> imm 0x0000FFFF, ctl 0001; sll shamt 3 (0x000108C0) -> ctl 1001, shamt 3; jal -> 1110.
//  Backpressure: stream 4 instrs, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, order kept, none lost.
//  Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed instrs never appear.
//  Illegal opcode 0x3F (0xFC000000) -> out_illegal=1, ctl 0000, imm 0; funct 111111 R-type also illegal.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control codes, MIPS-I opcode/funct constants and the ID/EX control bundle.
package mips_alu_pkg;
    localparam int DATA_W = 32;
    localparam int CTL_W  = 4;

    localparam logic [CTL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [CTL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [CTL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [CTL_W-1:0] ALU_ADDU  = 4'b0011;
    localparam logic [CTL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [CTL_W-1:0] ALU_SLT   = 4'b0111;
    localparam logic [CTL_W-1:0] ALU_LUI   = 4'b1000;
    localparam logic [CTL_W-1:0] ALU_SLL   = 4'b1001;
    localparam logic [CTL_W-1:0] ALU_SRL   = 4'b1010;
    localparam logic [CTL_W-1:0] ALU_XOR   = 4'b1011;
    localparam logic [CTL_W-1:0] ALU_PASSA = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct packed {
        logic [CTL_W-1:0]  alu_ctl;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              illegal;
    } ctl_bundle_t;
endpackage

// File: rtl/alu_ctl_issue_if.sv
// alu_ctl_issue_if: instruction-in / ALU-control-bundle-out handshake bus with flush.
interface alu_ctl_issue_if;
    logic                              flush;
    logic                              in_valid;
    logic                              in_ready;
    logic [mips_alu_pkg::DATA_W-1:0]   in_instr;
    logic                              out_valid;
    logic                              out_ready;
    logic [mips_alu_pkg::CTL_W-1:0]    out_alu_ctl;
    logic [4:0]                        out_shamt;
    logic [mips_alu_pkg::DATA_W-1:0]   out_imm;
    logic                              out_use_imm;
    logic                              out_illegal;

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_ctl, out_shamt, out_imm, out_use_imm, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_ctl, out_shamt, out_imm, out_use_imm, out_illegal
    );
endinterface

// File: rtl/alu_ctl_lut.sv
// alu_ctl_lut: combinational MIPS-I opcode/funct decode into the ALU control bundle.
module alu_ctl_lut
    import mips_alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output ctl_bundle_t       bundle
);
    logic [5:0] op;
    logic [5:0] fn;
    logic       zext;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign fn          = instr[5:0];
    assign unused_bits = &{1'b0, instr[25:16]};

    always_comb begin
        bundle  = '0;
        zext    = 1'b0;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_ADD, FN_JR:   bundle.alu_ctl = ALU_ADD;
                FN_ADDU:         bundle.alu_ctl = ALU_ADDU;
                FN_SUB, FN_SUBU: bundle.alu_ctl = ALU_SUB;
                FN_AND:          bundle.alu_ctl = ALU_AND;
                FN_OR:           bundle.alu_ctl = ALU_OR;
                FN_XOR:          bundle.alu_ctl = ALU_XOR;
                FN_SLT:          bundle.alu_ctl = ALU_SLT;
                FN_SLL:          bundle = '{alu_ctl: ALU_SLL, shamt: instr[10:6], default: '0};
                FN_SRL:          bundle = '{alu_ctl: ALU_SRL, shamt: instr[10:6], default: '0};
                default:         bundle.illegal = 1'b1;
            endcase
        end else begin
            bundle.use_imm = 1'b1;
            case (op)
                OP_ADDI, OP_LW, OP_SW: bundle.alu_ctl = ALU_ADD;
                OP_ADDIU:              bundle.alu_ctl = ALU_ADDU;
                OP_SLTI:               bundle.alu_ctl = ALU_SLT;
                OP_ANDI:               {bundle.alu_ctl, zext} = {ALU_AND, 1'b1};
                OP_ORI:                {bundle.alu_ctl, zext} = {ALU_OR, 1'b1};
                OP_XORI:               {bundle.alu_ctl, zext} = {ALU_XOR, 1'b1};
                OP_LUI:                {bundle.alu_ctl, zext} = {ALU_LUI, 1'b1};
                OP_BEQ, OP_BNE:        {bundle.alu_ctl, bundle.use_imm} = {ALU_SUB, 1'b0};
                OP_J:                  {bundle.alu_ctl, bundle.use_imm} = {ALU_ADD, 1'b0};
                OP_JAL:                {bundle.alu_ctl, bundle.use_imm} = {ALU_PASSA, 1'b0};
                default:               {bundle.illegal, bundle.use_imm} = 2'b10;
            endcase
            // Branches, jumps and illegal ops carry no immediate.
            bundle.imm = !bundle.use_imm ? '0 :
                         zext ? {16'b0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
        end
    end
endmodule

// File: rtl/alu_ctl_issue.sv
// alu_ctl_issue: registered ID/EX ALU-control issue stage with a one-entry skid buffer.
module alu_ctl_issue
    import mips_alu_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    alu_ctl_issue_if.slave bus
);
    ctl_bundle_t dec;
    ctl_bundle_t out_q;
    ctl_bundle_t skid_q;
    logic        out_v;
    logic        skid_v;
    logic        accept;
    logic        out_free;

    alu_ctl_lut u_lut (.instr(bus.in_instr), .bundle(dec));

    // in_ready comes straight from the skid flop, so there is no comb in->out path.
    assign accept   = bus.in_valid & ~skid_v;
    assign out_free = ~out_v | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_free) begin
            out_v  <= skid_v | accept;
            out_q  <= skid_v ? skid_q : accept ? dec : out_q;
            skid_v <= 1'b0;
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign bus.in_ready    = ~skid_v;
    assign bus.out_valid   = out_v;
    assign bus.out_alu_ctl = out_q.alu_ctl;
    assign bus.out_shamt   = out_q.shamt;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_use_imm = out_q.use_imm;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_alu_ctl_issue.sv
// tb_alu_ctl_issue: table-driven decode vectors plus scoreboard-checked handshake, flush and reset sequences.
module tb_alu_ctl_issue;
    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  ctl;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } vec_t;

    localparam int NV = 29;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    alu_ctl_issue_if bus ();
    alu_ctl_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    vec_t        v [NV];
    logic [42:0] q [$];
    logic [42:0] cur_exp;
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [42:0] ex(input vec_t x);
        return {x.ctl, x.shamt, x.imm, x.use_imm, x.illegal};
    endfunction

    function automatic logic [42:0] act();
        return {bus.out_alu_ctl, bus.out_shamt, bus.out_imm, bus.out_use_imm, bus.out_illegal};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    // Scoreboard: push on accepted input, pop on accepted output; flush and reset empty it.
    always @(negedge clk) begin
        if (!rst_n || bus.flush) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got %0h want no output", act());
                end else chk("sb_order", act(), q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
        end
    end

    task automatic send_one(input int i);
        bus.in_valid = 1'b1;
        bus.in_instr = v[i].instr;
        cur_exp      = ex(v[i]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int   k;
        logic acc;
        v[0]  = '{32'h2001FFFF, 4'b0010, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b0};
        v[1]  = '{32'h3401FFFF, 4'b0001, 5'd0,  32'h0000FFFF, 1'b1, 1'b0};
        v[2]  = '{32'h000108C0, 4'b1001, 5'd3,  32'h0,        1'b0, 1'b0};
        v[3]  = '{32'h0C000010, 4'b1110, 5'd0,  32'h0,        1'b0, 1'b0};
        v[4]  = '{32'hFC000000, 4'b0000, 5'd0,  32'h0,        1'b0, 1'b1};
        v[5]  = '{32'h0000003F, 4'b0000, 5'd0,  32'h0,        1'b0, 1'b1};
        v[6]  = '{32'h00000000, 4'b1001, 5'd0,  32'h0,        1'b0, 1'b0};
        v[7]  = '{32'h00221820, 4'b0010, 5'd0,  32'h0,        1'b0, 1'b0};
        v[8]  = '{32'h00221821, 4'b0011, 5'd0,  32'h0,        1'b0, 1'b0};
        v[9]  = '{32'h00221822, 4'b0110, 5'd0,  32'h0,        1'b0, 1'b0};
        v[10] = '{32'h00221823, 4'b0110, 5'd0,  32'h0,        1'b0, 1'b0};
        v[11] = '{32'h00221824, 4'b0000, 5'd0,  32'h0,        1'b0, 1'b0};
        v[12] = '{32'h00221825, 4'b0001, 5'd0,  32'h0,        1'b0, 1'b0};
        v[13] = '{32'h00221826, 4'b1011, 5'd0,  32'h0,        1'b0, 1'b0};
        v[14] = '{32'h0022182A, 4'b0111, 5'd0,  32'h0,        1'b0, 1'b0};
        v[15] = '{32'h000107C2, 4'b1010, 5'd31, 32'h0,        1'b0, 1'b0};
        v[16] = '{32'h03E00008, 4'b0010, 5'd0,  32'h0,        1'b0, 1'b0};
        v[17] = '{32'h24018000, 4'b0011, 5'd0,  32'hFFFF8000, 1'b1, 1'b0};
        v[18] = '{32'h28018000, 4'b0111, 5'd0,  32'hFFFF8000, 1'b1, 1'b0};
        v[19] = '{32'h30018000, 4'b0000, 5'd0,  32'h00008000, 1'b1, 1'b0};
        v[20] = '{32'h3801F000, 4'b1011, 5'd0,  32'h0000F000, 1'b1, 1'b0};
        v[21] = '{32'h3C01ABCD, 4'b1000, 5'd0,  32'h0000ABCD, 1'b1, 1'b0};
        v[22] = '{32'h8C01FFFC, 4'b0010, 5'd0,  32'hFFFFFFFC, 1'b1, 1'b0};
        v[23] = '{32'hAC010004, 4'b0010, 5'd0,  32'h00000004, 1'b1, 1'b0};
        v[24] = '{32'h1022FFFF, 4'b0110, 5'd0,  32'h0,        1'b0, 1'b0};
        v[25] = '{32'h14000003, 4'b0110, 5'd0,  32'h0,        1'b0, 1'b0};
        v[26] = '{32'h08000001, 4'b0010, 5'd0,  32'h0,        1'b0, 1'b0};
        v[27] = '{32'h000107C1, 4'b0000, 5'd0,  32'h0,        1'b0, 1'b1};
        v[28] = '{32'h80000000, 4'b0000, 5'd0,  32'h0,        1'b0, 1'b1};
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        cur_exp       = '0;
        #1 rst_n = 1'b0;
        #7;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_data", act(), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Decode sweep: each vector issued with out_ready=1, result expected one cycle later.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send_one(i);
            @(negedge clk);
            chk($sformatf("dec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("dec%0d_%08h", i, v[i].instr), act(), ex(v[i]));
            @(posedge clk); #1;
        end

        // Backpressure: 4 back-to-back instructions, out_ready low for the first 3 cycles.
        k = 0;
        for (int c = 0; c < 20 && (k < 4 || q.size() != 0); c++) begin
            bus.out_ready = (c >= 3);
            bus.in_valid  = (k < 4);
            if (k < 4) begin
                bus.in_instr = v[k].instr;
                cur_exp      = ex(v[k]);
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (c == 2) begin
                chk("bp_in_ready_low", bus.in_ready, 0);
                chk("bp_accepts", k, 2);
                chk("bp_hold", act(), ex(v[0]));
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_sent", k, 4);
        chk("bp_drained", q.size(), 0);

        // Flush with skid full and a pending input.
        bus.out_ready = 1'b0;
        send_one(4);
        send_one(5);
        bus.in_valid = 1'b1;
        bus.in_instr = v[6].instr;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("fl_skid_full", bus.in_ready, 0);
        chk("fl_out_held", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("fl_idle", bus.out_valid, 0);
        end

        // Flush beats both a same-cycle accept and out_ready.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_one(7);
        bus.in_valid  = 1'b1;
        bus.in_instr  = v[8].instr;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl2_out_valid", bus.out_valid, 0);
        chk("fl2_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        send_one(9);
        @(negedge clk);
        chk("fl2_resume", act(), ex(v[9]));
        @(posedge clk); #1;

        // Reset mid-stream with out_valid=1 and the skid full.
        bus.out_ready = 1'b0;
        send_one(10);
        send_one(11);
        @(negedge clk);
        chk("mr_pre_valid", bus.out_valid, 1);
        chk("mr_pre_ready", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_in_ready", bus.in_ready, 1);
        chk("mr_data", act(), 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_one(12);
        @(negedge clk);
        chk("mr_resume", act(), ex(v[12]));
        repeat (3) @(posedge clk);
        #1;
        chk("end_sb_empty", q.size(), 0);
        chk("end_out_valid", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
